// File: rtl/subneg_pkg.sv
// Shared state encoding and branch helpers for the SUBNEG core.
package subneg_pkg;

  localparam int FN_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_READ,
    ST_EXEC,
    ST_HALT
  } state_t;

  function automatic logic borrow_of(input logic [FN_W-1:0] val_a,
                                     input logic [FN_W-1:0] val_b);
    return val_a > val_b;
  endfunction

  // Operands arrive zero-extended to FN_W; caller truncates the result to ADDR_W.
  function automatic logic [FN_W-1:0] next_pc_of(input logic [FN_W-1:0] val_a,
                                                 input logic [FN_W-1:0] val_b,
                                                 input logic [FN_W-1:0] addr_c,
                                                 input logic [FN_W-1:0] pc_seq);
    return borrow_of(val_a, val_b) ? addr_c : pc_seq;
  endfunction

endpackage

// File: rtl/subneg_mem.sv
// MEM_DEPTH x DATA_W register array: three combinational reads, one write.
// Addresses at or beyond MEM_DEPTH read as zero and are never written.
module subneg_mem
  import subneg_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int MEM_DEPTH = 30
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] rd_addr_c,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] rd_data_c
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH;
  endfunction

  assign rd_data_a = in_range(rd_addr_a) ? mem[rd_addr_a] : '0;
  assign rd_data_b = in_range(rd_addr_b) ? mem[rd_addr_b] : '0;
  assign rd_data_c = in_range(rd_addr_c) ? mem[rd_addr_c] : '0;

  // Contents deliberately survive reset so a loaded program can be rerun.
  always_ff @(posedge clk) begin
    if (we && in_range(wr_addr)) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/subneg_core.sv
// SUBNEG one-instruction core: mem[b] -= mem[a]; branch to c on borrow.
//   state | meaning
//   IDLE  | waiting for run/step; program load accepted
//   FETCH | latch operand addresses a, b, c from mem[pc..pc+2]
//   READ  | latch operand values (with IN/OUT mapping)
//   EXEC  | write result, update pc and icount
//   HALT  | self-loop seen; only reset leaves, load still accepted
module subneg_core
  import subneg_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int MEM_DEPTH = 30,
  parameter int OUT_ADDR  = 31,
  parameter int IN_ADDR   = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              busy,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       icount
);

  localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_ADDR);
  localparam logic [ADDR_W-1:0] IN_A  = ADDR_W'(IN_ADDR);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q, addr_a_q, addr_b_q, addr_c_q;
  logic [DATA_W-1:0] val_a_q, val_b_q, out_data_q;
  logic [DATA_W-1:0] val_a_d, val_b_d;
  logic              out_valid_q;
  logic [15:0]       icount_q;

  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, rd_addr_c, wr_addr;
  logic [DATA_W-1:0] rd_data_a, rd_data_b, rd_data_c, wr_data;
  logic              we, load_ok, in_exec;

  logic [DATA_W-1:0] res;
  logic              borrow, halt_hit;
  logic [ADDR_W-1:0] pc_seq, pc_next;
  logic              unused_fetch_hi;

  subneg_mem #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk       (clk),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_addr_c (rd_addr_c),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_data_c (rd_data_c)
  );

  // Ports A/B carry pc/pc+1 during FETCH and the operand addresses during READ.
  assign rd_addr_a = (state_q == ST_READ) ? addr_a_q : pc_q;
  assign rd_addr_b = (state_q == ST_READ) ? addr_b_q : pc_q + ADDR_W'(1);
  assign rd_addr_c = pc_q + ADDR_W'(2);
  assign unused_fetch_hi = ^rd_data_c;

  always_comb begin
    val_a_d = rd_data_a;
    val_b_d = rd_data_b;
    if (addr_a_q == IN_A)       val_a_d = in_data;
    else if (addr_a_q == OUT_A) val_a_d = out_data_q;
    if (addr_b_q == IN_A)       val_b_d = in_data;
    else if (addr_b_q == OUT_A) val_b_d = out_data_q;
  end

  assign res      = val_b_q - val_a_q;
  assign borrow   = borrow_of(FN_W'(val_a_q), FN_W'(val_b_q));
  assign pc_seq   = pc_q + ADDR_W'(3);
  assign pc_next  = ADDR_W'(next_pc_of(FN_W'(val_a_q), FN_W'(val_b_q),
                                       FN_W'(addr_c_q), FN_W'(pc_seq)));
  assign halt_hit = borrow && (addr_c_q == pc_q);

  // Reset gates the write so an aborted EXEC never touches memory.
  assign in_exec = (state_q == ST_EXEC);
  assign load_ok = ld_we && ((state_q == ST_IDLE) || (state_q == ST_HALT));
  assign we      = !reset && (in_exec || load_ok);
  assign wr_addr = in_exec ? addr_b_q : ld_addr;
  assign wr_data = in_exec ? res : ld_data;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (run || step) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_READ;
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC: begin
        if (halt_hit)  state_d = ST_HALT;
        else if (run)  state_d = ST_FETCH;
        else           state_d = ST_IDLE;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      addr_c_q    <= '0;
      val_a_q     <= '0;
      val_b_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      icount_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          addr_a_q <= rd_data_a[ADDR_W-1:0];
          addr_b_q <= rd_data_b[ADDR_W-1:0];
          addr_c_q <= rd_data_c[ADDR_W-1:0];
        end
        ST_READ: begin
          val_a_q <= val_a_d;
          val_b_q <= val_b_d;
        end
        ST_EXEC: begin
          pc_q <= pc_next;
          if (icount_q != 16'hFFFF) icount_q <= icount_q + 16'd1;
          if (addr_b_q == OUT_A) begin
            out_data_q  <= res;
            out_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = (state_q == ST_HALT);
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_READ) || (state_q == ST_EXEC);
  assign pc        = pc_q;
  assign icount    = icount_q;

endmodule
